// File: rtl/r4k_pkg.sv
`default_nettype none
// ============================================================================
// Module   : r4k_pkg
// Brief    : Shared R4K types for the multiply/divide unit: the operation
//            encoding, the FSM state type and small operation-class helpers.
// Revision : 1.0 - initial release
// ============================================================================
package r4k_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_iter(input muldiv_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/r4k_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : r4k_muldiv
// Brief    : Iterative radix-2 multiply / restoring divide unit owning HI/LO.
//            Define R4K_MULDIV_EARLY_OUT_EN to end multiplies once the
//            remaining multiplier is zero.
// Revision : 1.0 - initial release
// ============================================================================
module r4k_muldiv
  import r4k_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  muldiv_op_t      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int                c_CNT_W    = $clog2(XLEN) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  muldiv_state_t       r_state;
  logic                r_is_div;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [XLEN-1:0]     r_hi;
  logic [XLEN-1:0]     r_lo;
  logic                r_done;

  logic                w_sa;
  logic                w_sb;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN-1:0]     w_mplier_next;
  logic [XLEN:0]       w_rem_sh;
  logic                w_ge;
  logic [XLEN-1:0]     w_rem_new;
  logic [2*XLEN-1:0]   w_div_next;
  logic                w_last;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;

  assign busy      = (r_state != IDLE);
  assign req_ready = !busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;

  // Signed ops run on magnitudes; the sign is restored in FIX.
  assign w_sa    = op_is_signed(req_op) && req_a[XLEN-1];
  assign w_sb    = op_is_signed(req_op) && req_b[XLEN-1];
  assign w_mag_a = w_sa ? -req_a : req_a;
  assign w_mag_b = w_sb ? -req_b : req_b;

  assign w_mul_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;

  // Divide keeps {remainder, quotient} in r_acc and the divisor in r_mcand.
  // A zero divisor naturally yields quotient all-ones and remainder = dividend.
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_mcand[XLEN-1:0]});
  assign w_rem_new  = w_ge ? (w_rem_sh[XLEN-1:0] - r_mcand[XLEN-1:0])
                           : w_rem_sh[XLEN-1:0];
  assign w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};

`ifdef R4K_MULDIV_EARLY_OUT_EN
  assign w_last = (r_cnt == c_CNT_LAST) || (!r_is_div && (w_mplier_next == '0));
`else
  assign w_last = (r_cnt == c_CNT_LAST);
`endif

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (req_op == MTHI) begin
              r_hi <= req_a;
            end else if (req_op == MTLO) begin
              r_lo <= req_a;
            end else if (op_is_iter(req_op)) begin
              r_state  <= RUN;
              r_is_div <= op_is_div(req_op);
              r_neg_q  <= w_sa ^ w_sb;
              r_neg_r  <= w_sa;
              r_cnt    <= '0;
              r_mplier <= w_mag_b;
              if (op_is_div(req_op)) begin
                r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                r_mcand <= {{XLEN{1'b0}}, w_mag_b};
              end else begin
                r_acc   <= '0;
                r_mcand <= {{XLEN{1'b0}}, w_mag_a};
              end
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt + c_CNT_ONE;
          if (r_is_div) begin
            r_acc <= w_div_next;
          end else begin
            r_acc    <= w_mul_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_next;
          end
          if (w_last) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*XLEN-1:XLEN];
            r_lo <= w_prod[XLEN-1:0];
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_r4k_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_r4k_muldiv
// Brief    : Self-checking bench for r4k_muldiv (XLEN=64): directed table,
//            hand-written corner sequences and a randomized model comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_r4k_muldiv;
  import r4k_pkg::*;

  localparam int XLEN = 64;
  localparam logic [63:0] c_MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  muldiv_op_t      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] m_hi = '0;
  logic [63:0] m_lo = '0;

  r4k_muldiv #(.XLEN(XLEN)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] hi;
    logic [63:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Architectural result from plain integer arithmetic.
  function automatic void model(input muldiv_op_t op, input logic [63:0] a,
                                input logic [63:0] b,
                                output logic [63:0] eh, output logic [63:0] el);
    logic [127:0]       p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = a;
    sb = b;
    eh = m_hi;
    el = m_lo;
    case (op)
      MULT: begin
        p  = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        eh = p[127:64];
        el = p[63:0];
      end
      MULTU: begin
        p  = {64'd0, a} * {64'd0, b};
        eh = p[127:64];
        el = p[63:0];
      end
      DIV: begin
        if (b == 64'd0) begin
          el = a[63] ? 64'd1 : c_ONES;
          eh = a;
        end else if (a == c_MIN && b == c_ONES) begin
          el = c_MIN;
          eh = 64'd0;
        end else begin
          el = sa / sb;
          eh = sa % sb;
        end
      end
      DIVU: begin
        if (b == 64'd0) begin
          el = c_ONES;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
      MTHI: eh = a;
      MTLO: el = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input muldiv_op_t op, input logic [63:0] b);
    logic [63:0] m;
    int          msb;
    m   = (op == MULT && b[63]) ? -b : b;
    msb = 0;
    for (int i = 0; i < 64; i++) if (m[i]) msb = i;
`ifdef R4K_MULDIV_EARLY_OUT_EN
    if (op == MULT || op == MULTU) return msb + 2;
`endif
    return (msb >= 0) ? XLEN + 1 : 0;
  endfunction

  // Called at a negedge; issues one request and follows it to completion.
  task automatic do_op(input string nm, input muldiv_op_t op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] eh, input logic [63:0] el);
    int n;
    bit seen;
    bit busy_ok;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("%s done_low_after_accept", nm), 128'(done), 128'(0));
    if (op == MTHI || op == MTLO) begin
      chk($sformatf("%s mt_busy", nm), 128'(busy), 128'(0));
      chk($sformatf("%s mt_hilo", nm), {hi, lo}, {eh, el});
    end else begin
      chk($sformatf("%s busy_after_accept", nm), 128'(busy), 128'(1));
      n       = 0;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (!seen && n < 200) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (done) seen = 1'b1;
        else if (!busy || ({hi, lo} !== {m_hi, m_lo})) busy_ok = 1'b0;
      end
      chk($sformatf("%s latency", nm), 128'(n), 128'(exp_lat(op, b)));
      chk($sformatf("%s busy_hold_during_run", nm), 128'(busy_ok), 128'(1));
      chk($sformatf("%s busy_in_done_cycle", nm), 128'(busy), 128'(0));
      chk($sformatf("%s hi", nm), 128'(hi), 128'(eh));
      chk($sformatf("%s lo", nm), 128'(lo), 128'(el));
    end
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    vec_t        tbl [11];
    logic [63:0] eh;
    logic [63:0] el;
    logic [63:0] ra;
    logic [63:0] rb;
    muldiv_op_t  rop;
    int          n;
    bit          seen;

    tbl[0]  = '{MULTU, 64'd3, 64'd5, 64'd0, 64'd15};
    tbl[1]  = '{MULT, c_ONES, c_ONES, 64'd0, 64'd1};
    tbl[2]  = '{MULT, c_MIN, 64'd2, c_ONES, 64'd0};
    tbl[3]  = '{DIV, -64'd7, 64'd2, c_ONES, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[4]  = '{DIVU, 64'd10, 64'd0, 64'd10, c_ONES};
    tbl[5]  = '{DIV, -64'd10, 64'd0, -64'd10, 64'd1};
    tbl[6]  = '{DIV, c_MIN, c_ONES, 64'd0, c_MIN};
    tbl[7]  = '{MULTU, 64'd7, 64'd1, 64'd0, 64'd7};
    tbl[8]  = '{MULTU, 64'd5, 64'h80, 64'd0, 64'h280};
    tbl[9]  = '{DIVU, 64'd100, 64'd7, 64'd2, 64'd14};
    tbl[10] = '{MTHI, 64'hABCD, 64'd0, 64'hABCD, 64'd14};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = MULTU;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset hi", 128'(hi), 128'(0));
    chk("reset lo", 128'(lo), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset ready", 128'(req_ready), 128'(1));
    reset = 1'b0;

    // Back-to-back: each op is issued in the done cycle of the previous one.
    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
    end

    // MTHI, then MULTU with req_valid held high (MTLO) throughout busy.
    do_op("mthi", MTHI, 64'h1234, 64'd0, 64'h1234, m_lo);
    req_valid = 1'b1;
    req_op    = MULTU;
    req_a     = 64'd2;
    req_b     = 64'd3;
    @(posedge clk);
    @(negedge clk);
    req_op = MTLO;
    req_a  = 64'd9;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    req_valid = 1'b0;
    chk("held latency", 128'(n), 128'(exp_lat(MULTU, 64'd3)));
    chk("held hi", 128'(hi), 128'(0));
    chk("held lo", 128'(lo), 128'(6));
    @(posedge clk);
    @(negedge clk);
    chk("held lo_after", 128'(lo), 128'(6));
    m_hi = 64'd0;
    m_lo = 64'd6;

    // Reset in the middle of RUN discards the op and clears HI/LO.
    req_valid = 1'b1;
    req_op    = MULTU;
    req_a     = 64'd3;
    req_b     = c_ONES;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 128'(busy), 128'(0));
    chk("midreset hilo", {hi, lo}, 128'(0));
    chk("midreset done", 128'(done), 128'(0));
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("midreset no_done", 128'(seen), 128'(0));
    m_hi = 64'd0;
    m_lo = 64'd0;

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rop = muldiv_op_t'($urandom_range(0, 5));
      ra  = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb  = {$urandom, $urandom} >> $urandom_range(0, 63);
      case ($urandom_range(0, 5))
        0: ra = c_MIN;
        1: rb = c_ONES;
        2: rb = 64'd0;
        3: ra = -ra;
        4: rb = -rb;
        default: ;
      endcase
      model(rop, ra, rb, eh, el);
      do_op($sformatf("rnd%0d", i), rop, ra, rb, eh, el);
    end

    @(negedge clk);
    chk("final done_low", 128'(done), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
